leb128_stream_decoder: RTL and testbench
========================================

// Module: leb128_stream_decoder
// PURPOSE
//  Byte-serial LEB128 decoder for the wasm fetch/decode path.
//  Accepts one bytecode byte per valid/ready beat and accumulates the 7-bit groups.
//  Emits one registered result per LEB128 item: value, byte count and error flag.
//  Handles unsigned/signed mode per item and OUT_W = 32 (i32/u32) or 64 (i64).
//  Detects over-long and non-canonical-overflow encodings.
// PARAMETERS
//  OUT_W      32   result width; legal values 32 or 64
//  MAX_BYTES  (OUT_W+6)/7   max encoded length (5 for 32, 10 for 64); derived, not overridden
//  CNT_W      4    width of out_byte_cnt; must hold MAX_BYTES
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  flush         in   1      sync clear; abandons any partial item
//  in_valid      in   1      in_byte valid
//  in_ready      out  1      decoder accepts in_byte this cycle
//  in_byte       in   8      bit7 = continuation, [6:0] = payload
//  in_signed     in   1      sampled on the first byte of an item; 1 = sLEB128
//  out_valid     out  1      result valid
//  out_ready     in   1      consumer takes result
//  out_value     out  OUT_W  decoded value, sign- or zero-extended
//  out_byte_cnt  out  CNT_W  bytes consumed by this item (1..MAX_BYTES)
//  out_err       out  1      1 = malformed item; out_value is 0
//  out_err_code  out  2      00 none, 01 too long, 10 unused final bits invalid
// BEHAVIOUR
//  Reset: state IDLE, acc=0, cnt=0; out_valid=0, out_value=0, out_byte_cnt=0, out_err=0, out_err_code=0.
//  Reset mid-item discards all partial state.
//  Handshake:
//   - in_ready = !flush && (!out_valid || out_ready), i.e. one output register, pass-through on pop.
//   - Byte accepted when in_valid && in_ready.
//   - Result held stable while out_valid && !out_ready.
//  State machine:
//   - IDLE, ACCUM: accumulate/finish as below.
//   - Output register holds the result.
//   - IDLE + accepted byte: latch in_signed into sgn; acc=payload; cnt=1. If bit7=0, finish now; else go to ACCUM.
//   - ACCUM + accepted byte: acc |= payload << 7*cnt (bits past OUT_W dropped); cnt++. If bit7=0, finish and go to IDLE.
//  Finish: load the output register on the same clock edge that the terminating byte is accepted.
//  Latency: out_valid rises 1 cycle after the last byte handshake.
//   - Unsigned: out_value = acc, zero-extended.
//   - Signed, with shift = 7*cnt < OUT_W and final payload bit6 = 1: bits [OUT_W-1:shift] = 1.
//  Errors (finish immediately with out_err=1, out_value=0, go to IDLE):
//   - code 01: byte number MAX_BYTES arrives with bit7=1.
//   - code 10: final byte at index MAX_BYTES-1 has payload bits at positions >= OUT_W that are illegal.
//     Unsigned: those bits must be 0.
//     Signed: those bits must all equal bit (OUT_W-1).
//     Unused bits are [6:4] for OUT_W=32 and [6:1] for OUT_W=64.
//  out_byte_cnt on error = bytes consumed, including the offending byte.
//  Bytes after an error start a new item; the parent is expected to trap or flush.
//  flush: return to IDLE, clear acc/cnt and out_valid on the next edge. No byte is accepted while flush=1. flush wins over every other event.
//  Simultaneous pop + new terminating byte: the new result replaces the old one, and out_valid stays 1.
// STRUCTURE
//  Shared package leb128_pkg:
//   - err_code enum (LEB_OK, LEB_TOO_LONG, LEB_BAD_TAIL)
//   - function leb_max_bytes(OUT_W)
//   - state enum (S_IDLE, S_ACCUM)
//  Sub-module leb128_tail_check (combinational), ports:
//   - inputs: payload[6:0], sgn, byte_idx, acc_msb
//   - output: ok
//   It applies the unused-bit rule above; keep it separate so it can be unit-tested.
//  Everything else is in this file: acc/cnt registers, FSM, output register.
// TESTING
//  1 Unsigned, OUT_W=32: E5 8E 26 -> value 0x00098765 (624485), cnt=3, err=0.
//  2 Signed, OUT_W=32:
//    7F -> 0xFFFFFFFF, cnt=1.
//    C0 BB 78 -> 0xFFFE1DC0 (-123456), cnt=3.
//  3 Boundary, OUT_W=32:
//    80 80 80 80 0F unsigned -> 0xF0000000, cnt=5.
//    80 80 80 80 10 -> err=1, code 10, cnt=5.
//    Signed FF FF FF FF 7F -> 0xFFFFFFFF, ok.
//  4 Too long, OUT_W=32: FF FF FF FF FF -> err=1, code 01, cnt=5. Next byte 05 -> value 5, cnt=1.
//  5 Back-pressure:
//    Hold out_ready=0 with result pending -> in_ready=0, out_value stable for 10 cycles.
//    Release out_ready -> pop, then same-cycle accept of 01 -> out_valid stays 1, value 1.
//  6 Reset/flush:
//    Send 80 80, then assert flush -> next item 02 gives value 2, cnt=1.
//    Repeat with rst_n pulsed low mid-item -> all outputs 0, next item decodes cleanly.
//    OUT_W=64 run: unsigned FF x9 01 -> 0xFFFFFFFFFFFFFFFF, cnt=10.

Source files
------------

// File: rtl/leb128_pkg.sv
// Shared types and helpers for the LEB128 byte-stream decoder.
// Error codes and FSM states used by the decoder and its tail checker.
package leb128_pkg;

  typedef enum logic [1:0] {
    LEB_OK       = 2'b00,
    LEB_TOO_LONG = 2'b01,
    LEB_BAD_TAIL = 2'b10
  } err_code_e;

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_e;

  function automatic int leb_max_bytes(input int out_w);
    return (out_w + 6) / 7;
  endfunction

endpackage

// File: rtl/leb128_tail_check.sv
// Validates the unused high payload bits of the last legal byte.
// Bits past OUT_W must be zero (unsigned) or copies of the sign (signed).
module leb128_tail_check
  import leb128_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int CNT_W = 4
) (
  input  logic [6:0]       payload,
  input  logic             sgn,
  input  logic [CNT_W-1:0] byte_idx,
  input  logic             acc_msb,
  output logic             ok
);

  localparam int MAXB = leb_max_bytes(OUT_W);
  localparam int USED = OUT_W - 7 * (MAXB - 1);

  logic       last;
  logic [6:0] hi;
  logic [6:0] hi_exp;

  assign last   = byte_idx == CNT_W'(MAXB - 1);
  assign hi     = payload >> USED;
  assign hi_exp = (sgn && acc_msb) ? (7'h7f >> USED) : 7'h00;
  assign ok     = !last || (hi == hi_exp);

endmodule

// File: rtl/leb128_stream_decoder.sv
// Byte-serial LEB128 decoder: one byte per beat in, one registered
// result (value, byte count, error) per item out.
module leb128_stream_decoder
  import leb128_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic [CNT_W-1:0] out_byte_cnt,
  output logic             out_err,
  output logic [1:0]       out_err_code
);

  localparam int MAXB = leb_max_bytes(OUT_W);

  state_e           state_q;
  logic [OUT_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_q;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_value_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_err_q;
  err_code_e        out_code_q;

  logic             fire;
  logic             first;
  logic             sgn_d;
  logic             last;
  logic             too_long;
  logic             tail_ok;
  logic             finish;
  logic             neg;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt_d;
  logic [6:0]       sh_cur;
  logic [6:0]       sh_nxt;
  logic [OUT_W-1:0] acc_d;
  logic [OUT_W-1:0] val_d;
  err_code_e        code_d;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;
  assign first    = state_q == S_IDLE;
  assign idx      = first ? '0 : cnt_q;
  assign cnt_d    = idx + 1'b1;
  assign sgn_d    = first ? in_signed : sgn_q;
  assign sh_cur   = 7'(idx) * 7'd7;
  assign sh_nxt   = 7'(cnt_d) * 7'd7;

  // Payload bits shifted past OUT_W fall off the top.
  assign acc_d = (first ? '0 : acc_q)
               | (OUT_W'(in_byte[6:0]) << sh_cur);

  assign last     = !in_byte[7];
  assign too_long = in_byte[7] && (cnt_d == CNT_W'(MAXB));
  assign finish   = last || too_long;
  assign neg      = sgn_d && in_byte[6] && (sh_nxt < 7'(OUT_W));

  leb128_tail_check #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_tail (
    .payload  (in_byte[6:0]),
    .sgn      (sgn_d),
    .byte_idx (idx),
    .acc_msb  (acc_d[OUT_W-1]),
    .ok       (tail_ok)
  );

  always_comb begin
    code_d = LEB_OK;
    val_d  = neg ? (acc_d | ({OUT_W{1'b1}} << sh_nxt)) : acc_d;
    if (too_long) begin
      code_d = LEB_TOO_LONG;
    end else if (!tail_ok) begin
      code_d = LEB_BAD_TAIL;
    end
    if (code_d != LEB_OK) begin
      val_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_cnt_q   <= '0;
      out_err_q   <= 1'b0;
      out_code_q  <= LEB_OK;
    end else if (flush) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (fire) begin
        if (finish) begin
          state_q     <= S_IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          out_value_q <= val_d;
          out_cnt_q   <= cnt_d;
          out_err_q   <= code_d != LEB_OK;
          out_code_q  <= code_d;
        end else begin
          state_q <= S_ACCUM;
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          sgn_q   <= sgn_d;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign out_byte_cnt = out_cnt_q;
  assign out_err      = out_err_q;
  assign out_err_code = out_code_q;

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Scoreboard bench for leb128_stream_decoder, OUT_W=32 and OUT_W=64.
// Expected results come from an integer-level LEB128 model.
module tb_leb128_stream_decoder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [63:0] val;
    int          cnt;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush;

  logic        v32, rdy32, s32, ov32, or32, e32;
  logic [7:0]  b32;
  logic [31:0] val32;
  logic [3:0]  cnt32;
  logic [1:0]  ec32;

  logic        v64, rdy64, s64, ov64, or64, e64;
  logic [7:0]  b64;
  logic [63:0] val64;
  logic [3:0]  cnt64;
  logic [1:0]  ec64;

  leb128_stream_decoder #(.OUT_W(32), .CNT_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v32), .in_ready(rdy32), .in_byte(b32),
    .in_signed(s32), .out_valid(ov32), .out_ready(or32),
    .out_value(val32), .out_byte_cnt(cnt32),
    .out_err(e32), .out_err_code(ec32)
  );

  leb128_stream_decoder #(.OUT_W(64), .CNT_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v64), .in_ready(rdy64), .in_byte(b64),
    .in_signed(s64), .out_valid(ov64), .out_ready(or64),
    .out_value(val64), .out_byte_cnt(cnt64),
    .out_err(e64), .out_err_code(ec64)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  bit   rdy_rand = 1'b0;
  exp_t q32[$];
  exp_t q64[$];

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string msg);
    n_chk++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  // Integer view: sum payload*128^i, sign-extend from bit 7n-1,
  // then require the number to be representable in w bits.
  function automatic exp_t model(input bq_t bs, input bit sg,
                                 input int w);
    logic [127:0] acc, hi, ones;
    logic [7:0]   b;
    exp_t         e;
    int           n;
    acc  = '0;
    ones = ~128'(0);
    n    = bs.size();
    for (int i = 0; i < n; i++) begin
      b = bs[i];
      acc |= 128'(b[6:0]) << (7 * i);
    end
    e.val = '0; e.cnt = n; e.err = 1'b0; e.code = 2'b00;
    b = bs[n-1];
    if (b[7]) begin
      e.err = 1'b1; e.code = 2'b01;
    end else begin
      if (sg && b[6]) acc |= ones << (7 * n);
      if (sg) begin
        hi = acc >> (w - 1);
        if (hi != 0 && hi != (ones >> (w - 1))) begin
          e.err = 1'b1; e.code = 2'b10;
        end
      end else begin
        hi = acc >> w;
        if (hi != 0) begin
          e.err = 1'b1; e.code = 2'b10;
        end
      end
      if (!e.err) e.val = (w == 64) ? acc[63:0] : {32'h0, acc[31:0]};
    end
    return e;
  endfunction

  function automatic bq_t rand_bytes(input int maxb);
    bq_t        bs;
    logic [7:0] b;
    int         n;
    n = $urandom_range(1, maxb);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (i < n - 1) b[7] = 1'b1;
      else if (n < maxb) b[7] = 1'b0;
      else if ($urandom_range(0, 3) != 0) b[7] = 1'b0;
      bs.push_back(b);
    end
    return bs;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && ov32 && or32) begin
      if (q32.size() == 0) begin
        fail_now($sformatf("out32_extra: got value %0h, expected none",
                           val32));
      end else begin
        e = q32.pop_front();
        cmp("val32", 64'(val32), e.val);
        cmp("cnt32", 64'(cnt32), 64'(e.cnt));
        cmp("err32", 64'(e32), 64'(e.err));
        cmp("code32", 64'(ec32), 64'(e.code));
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (rst_n && ov64 && or64) begin
      if (q64.size() == 0) begin
        fail_now($sformatf("out64_extra: got value %0h, expected none",
                           val64));
      end else begin
        e = q64.pop_front();
        cmp("val64", val64, e.val);
        cmp("cnt64", 64'(cnt64), 64'(e.cnt));
        cmp("err64", 64'(e64), 64'(e.err));
        cmp("code64", 64'(ec64), 64'(e.code));
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        or32 = $urandom_range(0, 3) != 0;
        or64 = $urandom_range(0, 3) != 0;
      end
    end
  end

  task automatic send32(input logic [7:0] b, input bit sg);
    int t;
    t = 0;
    v32 = 1'b1; b32 = b; s32 = sg;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy32 && t < 500);
    if (!rdy32) fail_now("in32_timeout: in_ready low 500 cycles, expected 1");
    @(posedge clk);
    #1;
    v32 = 1'b0; b32 = 8'($urandom); s32 = 1'($urandom);
  endtask

  task automatic send64(input logic [7:0] b, input bit sg);
    int t;
    t = 0;
    v64 = 1'b1; b64 = b; s64 = sg;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy64 && t < 500);
    if (!rdy64) fail_now("in64_timeout: in_ready low 500 cycles, expected 1");
    @(posedge clk);
    #1;
    v64 = 1'b0; b64 = 8'($urandom); s64 = 1'($urandom);
  endtask

  task automatic item(input int w, input bq_t bs, input bit sg,
                      input bit gaps);
    bit s;
    for (int i = 0; i < bs.size(); i++) begin
      s = (i == 0) ? sg : 1'($urandom);
      if (w == 64) send64(bs[i], s);
      else send32(bs[i], s);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic dir(input int w, input bq_t bs, input bit sg,
                     input logic [63:0] val, input int cnt,
                     input logic err, input logic [1:0] code);
    exp_t e;
    e.val = val; e.cnt = cnt; e.err = err; e.code = code;
    if (w == 64) q64.push_back(e);
    else q32.push_back(e);
    item(w, bs, sg, 1'b0);
  endtask

  task automatic rnd(input int w);
    bq_t bs;
    bit  sg;
    sg = 1'($urandom);
    bs = rand_bytes((w + 6) / 7);
    if (w == 64) q64.push_back(model(bs, sg, 64));
    else q32.push_back(model(bs, sg, 32));
    item(w, bs, sg, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rdy_rand = 1'b0;
    or32 = 1'b1;
    or64 = 1'b1;
    while ((q32.size() != 0 || q64.size() != 0 || ov32 || ov64)
           && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) fail_now("drain_timeout: results outstanding, expected none");
  endtask

  initial begin : main
    bq_t bs;
    rst_n = 1'b0; flush = 1'b0;
    v32 = 1'b0; b32 = '0; s32 = 1'b0; or32 = 1'b1;
    v64 = 1'b0; b64 = '0; s64 = 1'b0; or64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_valid32", 64'(ov32), 0);
    cmp("rst_value32", 64'(val32), 0);
    cmp("rst_cnt32", 64'(cnt32), 0);
    cmp("rst_err32", 64'(e32), 0);
    cmp("rst_code32", 64'(ec32), 0);
    cmp("rst_ready32", 64'(rdy32), 1);
    cmp("rst_valid64", 64'(ov64), 0);
    cmp("rst_value64", val64, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    dir(32, '{8'hE5, 8'h8E, 8'h26}, 0, 64'h0009_8765, 3, 0, 2'b00);
    dir(32, '{8'h7F}, 1, 64'hFFFF_FFFF, 1, 0, 2'b00);
    dir(32, '{8'h7F}, 0, 64'h0000_007F, 1, 0, 2'b00);
    dir(32, '{8'hC0, 8'hBB, 8'h78}, 1, 64'hFFFE_1DC0, 3, 0, 2'b00);
    dir(32, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h0F}, 0,
        64'hF000_0000, 5, 0, 2'b00);
    dir(32, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h10}, 0, 0, 5, 1, 2'b10);
    dir(32, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F}, 1,
        64'hFFFF_FFFF, 5, 0, 2'b00);
    dir(32, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 0, 5, 1, 2'b01);
    dir(32, '{8'h05}, 0, 64'h5, 1, 0, 2'b00);
    drain();

    // Back-pressure: result held, input stalled, then pop + accept.
    or32 = 1'b0;
    dir(32, '{8'h2A}, 0, 64'h2A, 1, 0, 2'b00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmp("bp_in_ready", 64'(rdy32), 0);
      cmp("bp_valid", 64'(ov32), 1);
      cmp("bp_value", 64'(val32), 64'h2A);
    end
    @(posedge clk);
    #1;
    or32 = 1'b1;
    dir(32, '{8'h01}, 0, 64'h1, 1, 0, 2'b00);
    cmp("pop_acc_valid", 64'(ov32), 1);
    cmp("pop_acc_value", 64'(val32), 1);
    drain();

    // Flush abandons a partial item.
    send32(8'h80, 1'b0);
    send32(8'h80, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    cmp("flush_in_ready", 64'(rdy32), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    dir(32, '{8'h02}, 0, 64'h2, 1, 0, 2'b00);
    drain();

    // Asynchronous reset mid-item.
    send32(8'h80, 1'b0);
    send32(8'h80, 1'b0);
    rst_n = 1'b0;
    #2;
    cmp("mid_rst_valid", 64'(ov32), 0);
    cmp("mid_rst_value", 64'(val32), 0);
    cmp("mid_rst_cnt", 64'(cnt32), 0);
    cmp("mid_rst_err", 64'(e32), 0);
    cmp("mid_rst_code", 64'(ec32), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dir(32, '{8'h03}, 0, 64'h3, 1, 0, 2'b00);
    drain();

    rdy_rand = 1'b1;
    repeat (300) rnd(32);
    drain();

    bs.delete();
    repeat (9) bs.push_back(8'hFF);
    bs.push_back(8'h01);
    dir(64, bs, 0, 64'hFFFF_FFFF_FFFF_FFFF, 10, 0, 2'b00);
    bs[9] = 8'h02;
    dir(64, bs, 0, 0, 10, 1, 2'b10);
    bs[9] = 8'h7F;
    dir(64, bs, 1, 64'hFFFF_FFFF_FFFF_FFFF, 10, 0, 2'b00);
    bs[9] = 8'hFF;
    dir(64, bs, 0, 0, 10, 1, 2'b01);
    dir(64, '{8'hC0, 8'hBB, 8'h78}, 1, 64'hFFFF_FFFF_FFFE_1DC0,
        3, 0, 2'b00);
    drain();

    rdy_rand = 1'b1;
    repeat (150) rnd(64);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
